// File: rtl/mem_map_pkg.sv
// mem_map_pkg: shared definitions for masters of the 64-word memory chip.
// Holds the access-sequencer state encoding, the memory map constants and
// a region decoder returning {mapped, writable}.
package mem_map_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int unsigned ROM_BASE      = 0;
    localparam int unsigned ROM_SIZE      = 16;
    localparam int unsigned RAM_LOW_BASE  = 16;
    localparam int unsigned RAM_LOW_SIZE  = 8;
    localparam int unsigned RAM_HIGH_BASE = 32;
    localparam int unsigned RAM_HIGH_SIZE = 8;

    typedef struct packed {
        logic mapped;
        logic writable;
    } region_t;

    // Unsigned wrap-around makes (addr - base) < size a single range test.
    function automatic region_t region_decode(input int unsigned addr);
        region_t r;
        r.mapped   = 1'b0;
        r.writable = 1'b0;
        if ((addr - ROM_BASE) < ROM_SIZE) begin
            r.mapped = 1'b1;
        end else if ((addr - RAM_LOW_BASE) < RAM_LOW_SIZE) begin
            r.mapped   = 1'b1;
            r.writable = 1'b1;
        end else if ((addr - RAM_HIGH_BASE) < RAM_HIGH_SIZE) begin
            r.mapped   = 1'b1;
            r.writable = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter_2_if.sv
// mem_arbiter_2_if: requester handshake plus memory-chip bus for the
// two-port arbiter. slave = arbiter side, master = requesters and memory.
interface mem_arbiter_2_if #(
    parameter int DW = 16,
    parameter int AW = 6
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic          err0;
    logic          err1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_in;
    logic          mem_rw;
    logic [DW-1:0] mem_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
        output ack0, ack1, err0, err1, rdata, mem_addr, mem_in, mem_rw
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
        input  ack0, ack1, err0, err1, rdata, mem_addr, mem_in, mem_rw
    );
endinterface

// File: rtl/mem_addr_check.sv
// mem_addr_check: combinational address decode into {mapped, writable},
// usable by any master of the memory chip.
module mem_addr_check
    import mem_map_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic [AW-1:0] addr,
    output logic          mapped,
    output logic          writable
);
    region_t region;

    // Decode the address against the memory map.
    always_comb begin
        region = region_decode(32'(addr));
    end

    assign mapped   = region.mapped;
    assign writable = region.writable;
endmodule

// File: rtl/mem_arbiter_2.sv
// mem_arbiter_2: round-robin two-port arbiter and RW sequencer for the
// 64-word memory chip. Writes go SETUP -> STROBE -> HOLD so address/data
// are stable around the one-cycle RW strobe; illegal accesses skip memory.
// Optional statistics counters are enabled with `define MEM_ARB_STATS_EN.
module mem_arbiter_2
    import mem_map_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 6
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_2_if.slave bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [7:0]     grant_cnt0,
    output logic [7:0]     grant_cnt1,
    output logic [7:0]     err_cnt
`endif
);
    state_t        state_reg;
    state_t        state_next;
    logic          last_grant_reg;
    logic          grant_reg;
    logic          we_reg;
    logic          reject_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [DW-1:0] mem_in_reg;
    logic [DW-1:0] rdata_reg;
    logic          mem_rw_reg;
    logic [1:0]    ack_reg;
    logic [1:0]    err_reg;

    logic          pick;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_mapped;
    logic          sel_writable;
    logic          sel_reject;
    logic          take;

    genvar gi;

    // Port 1 wins alone or when port 0 was served last; otherwise port 0.
    assign pick      = (bus.req0 && bus.req1) ? ~last_grant_reg : bus.req1;
    assign sel_we    = pick ? bus.we1    : bus.we0;
    assign sel_addr  = pick ? bus.addr1  : bus.addr0;
    assign sel_wdata = pick ? bus.wdata1 : bus.wdata0;

    mem_addr_check #(.AW(AW)) u_addr_check (
        .addr     (sel_addr),
        .mapped   (sel_mapped),
        .writable (sel_writable)
    );

    assign sel_reject = !sel_mapped || (sel_we && !sel_writable);

    // Next-state logic; rejected accesses go straight to DONE.
    always_comb begin
        state_next = state_reg;
        take       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    take       = 1'b1;
                    state_next = sel_reject ? DONE : SETUP;
                end
            end
            SETUP:   state_next = we_reg ? STROBE : DONE;
            STROBE:  state_next = HOLD;
            HOLD:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Capture the granted request; held unchanged for the whole access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_reg    <= 1'b0;
            we_reg       <= 1'b0;
            reject_reg   <= 1'b0;
            mem_addr_reg <= '0;
            mem_in_reg   <= '0;
        end else if (take) begin
            grant_reg    <= pick;
            we_reg       <= sel_we;
            reject_reg   <= sel_reject;
            mem_addr_reg <= sel_addr;
            mem_in_reg   <= sel_wdata;
        end
    end

    // Registered RW strobe, high only while in STROBE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_rw_reg <= 1'b0;
        else     mem_rw_reg <= (state_next == STROBE);
    end

    // Read data is sampled from the combinational memory output in SETUP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 rdata_reg <= '0;
        else if (state_reg == SETUP && !we_reg) rdata_reg <= bus.mem_out;
    end

    // Round-robin pointer moves when an access finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    last_grant_reg <= 1'b1;
        else if (state_reg == DONE) last_grant_reg <= grant_reg;
    end

    // Per-port completion and error pulses, issued the cycle after DONE.
    for (gi = 0; gi < 2; gi++) begin : g_port_resp
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ack_reg[gi] <= 1'b0;
                err_reg[gi] <= 1'b0;
            end else begin
                ack_reg[gi] <= (state_reg == DONE) && (grant_reg == 1'(gi));
                err_reg[gi] <= (state_reg == DONE) && (grant_reg == 1'(gi)) && reject_reg;
            end
        end
    end

    assign bus.ack0     = ack_reg[0];
    assign bus.ack1     = ack_reg[1];
    assign bus.err0     = err_reg[0];
    assign bus.err1     = err_reg[1];
    assign bus.rdata    = rdata_reg;
    assign bus.mem_addr = mem_addr_reg;
    assign bus.mem_in   = mem_in_reg;
    assign bus.mem_rw   = mem_rw_reg;

`ifdef MEM_ARB_STATS_EN
    logic [7:0] grant_cnt_reg [2];
    logic [7:0] err_cnt_reg;

    // Served-access counters per port, wrapping.
    for (gi = 0; gi < 2; gi++) begin : g_grant_cnt
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                grant_cnt_reg[gi] <= '0;
            else if (state_reg == DONE && grant_reg == 1'(gi))
                grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 8'd1;
        end
    end

    // Rejected-access counter, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt_reg <= '0;
        else if (state_reg == DONE && reject_reg && err_cnt_reg != 8'hFF)
            err_cnt_reg <= err_cnt_reg + 8'd1;
    end

    assign grant_cnt0 = grant_cnt_reg[0];
    assign grant_cnt1 = grant_cnt_reg[1];
    assign err_cnt    = err_cnt_reg;
`endif
endmodule

// File: tb/tb_mem_arbiter_2.sv
// tb_mem_arbiter_2: directed bench with a scoreboard queue for responses
// and a behavioural model of the memory chip (ROM word i = ~i).
module tb_mem_arbiter_2;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_arbiter_2_if #(.DW(16), .AW(6)) bus ();

`ifdef MEM_ARB_STATS_EN
    logic [7:0] grant_cnt0;
    logic [7:0] grant_cnt1;
    logic [7:0] err_cnt;
`endif

    mem_arbiter_2 #(.DW(16), .AW(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
        .err_cnt    (err_cnt)
`endif
    );

    // Memory chip model: combinational read, write while RW is high.
    logic [15:0] mem [64];
    assign bus.mem_out = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_rw) mem[bus.mem_addr] <= bus.mem_in;
    end

    typedef struct {
        logic [3:0]  flags;   // {ack1, ack0, err1, err0}
        logic [15:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: every response pulse is checked against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (bus.ack0 || bus.ack1 || bus.err0 || bus.err1)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", {28'd0, bus.ack1, bus.ack0, bus.err1, bus.err0}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("resp_flags", {28'd0, bus.ack1, bus.ack0, bus.err1, bus.err0}, {28'd0, e.flags});
                chk("resp_rdata", {16'd0, bus.rdata}, {16'd0, e.rdata});
            end
        end
    end

    // One access from one port; measures latency, strobe count, address hold.
    task automatic access(input bit port, input bit we, input logic [5:0] addr,
                          input logic [15:0] wdata, input bit exp_err,
                          input logic [15:0] exp_rdata, input int exp_lat);
        exp_t e;
        int   lat;
        int   rw_cycles;
        bit   addr_ok;
        bit   got;
        @(posedge clk); #1;
        e.flags = port ? {2'b10, exp_err, 1'b0} : {2'b01, 1'b0, exp_err};
        e.rdata = exp_rdata;
        sb_q.push_back(e);
        if (port) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end
        lat = 0; rw_cycles = 0; addr_ok = 1'b1; got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (bus.mem_rw) rw_cycles++;
            if (!exp_err && bus.mem_addr !== addr) addr_ok = 1'b0;
            got = port ? bus.ack1 : bus.ack0;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk("ack_seen", {31'd0, got}, 32'd1);
        chk("latency", lat, exp_lat);
        chk("strobe_cycles", rw_cycles, (we && !exp_err) ? 1 : 0);
        if (!exp_err) chk("addr_stable", {31'd0, addr_ok}, 32'd1);
    endtask

    // Both ports read continuously (port 0 at 32, port 1 at 33).
    task automatic contend(input int n);
        exp_t e;
        int   seen;
        int   cyc;
        for (int i = 0; i < n; i++) begin
            e.flags = (i % 2 == 0) ? 4'b0100 : 4'b1000;
            e.rdata = (i % 2 == 0) ? 16'hA020 : 16'hA021;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.we0 = 1'b0; bus.addr0 = 6'd32;
        bus.we1 = 1'b0; bus.addr1 = 6'd33;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        seen = 0; cyc = 0;
        while (seen < n && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.ack0 || bus.ack1) seen++;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk("contend_acks", seen, n);
        chk("contend_cycles", cyc, 3 * n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cyc;
        for (int i = 0; i < 64; i++) begin
            if (i < 16)                      mem[i] = ~16'(i);
            else if (i < 24 || (i >= 32 && i < 40)) mem[i] = 16'hA000 + 16'(i);
            else                             mem[i] = 16'h0000;
        end
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", {27'd0, bus.ack1, bus.ack0, bus.err1, bus.err0, bus.mem_rw}, 32'd0);
        chk("reset_mem_addr", {26'd0, bus.mem_addr}, 32'd0);
        chk("reset_mem_in", {16'd0, bus.mem_in}, 32'd0);
        chk("reset_rdata", {16'd0, bus.rdata}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Continuous contention straight after reset: 0,1,0,1.
        contend(4);

        // Write then read back RAM_LOW.
        access(1'b0, 1'b1, 6'd17, 16'h1234, 1'b0, 16'hA021, 5);
        access(1'b0, 1'b0, 6'd17, 16'h0000, 1'b0, 16'h1234, 3);

        // ROM read from port 1.
        access(1'b1, 1'b0, 6'd3, 16'h0000, 1'b0, 16'hFFFC, 3);

        // ROM write and unmapped read are rejected; rdata retained.
        access(1'b0, 1'b1, 6'd5, 16'h5555, 1'b1, 16'hFFFC, 2);
        access(1'b0, 1'b0, 6'd28, 16'h0000, 1'b1, 16'hFFFC, 2);
        chk("rom_untouched", {16'd0, mem[5]}, 32'h0000FFFA);

        // Reset in the middle of the write strobe.
        @(posedge clk); #1;
        bus.we1 = 1'b1; bus.addr1 = 6'd35; bus.wdata1 = 16'hBEEF; bus.req1 = 1'b1;
        wait_cyc = 0;
        while (!bus.mem_rw && wait_cyc < 20) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        chk("strobe_reached", {31'd0, bus.mem_rw}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_reset_outs", {27'd0, bus.ack1, bus.ack0, bus.err1, bus.err0, bus.mem_rw}, 32'd0);
        bus.req1 = 1'b0;
        repeat (2) @(posedge clk);
        chk("aborted_write_mem", {16'd0, mem[35]}, 32'h0000A023);
        @(negedge clk);
        rst = 1'b0;

        // First contended request after reset goes to port 0.
        contend(2);

        // Remaining accesses for the statistics counters.
        access(1'b0, 1'b0, 6'd17, 16'h0000, 1'b0, 16'h1234, 3);
        access(1'b0, 1'b1, 6'd5, 16'h7777, 1'b1, 16'h1234, 2);
        access(1'b1, 1'b0, 6'd3, 16'h0000, 1'b0, 16'hFFFC, 3);
`ifdef MEM_ARB_STATS_EN
        #1;
        chk("grant_cnt0", {24'd0, grant_cnt0}, 32'd3);
        chk("grant_cnt1", {24'd0, grant_cnt1}, 32'd2);
        chk("err_cnt", {24'd0, err_cnt}, 32'd1);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
